// File: rtl/bldc_pkg.sv
// ---------------------------------------------------------------------------
// bldc_pkg
// Shared types and constants for the BLDC gate driver slice.
//   leg_req_t    : what the decode logic asks a single inverter leg to do
//   leg_state_t  : per-leg FSM state (OFF / HI / LO / DEAD)
//   comm_entry_t : one commutation table row {source leg, sink leg}
//   COMM_TABLE   : the 6-step table, indexed by the commutation step
//   STEP_INVALID : first step value that is not a legal commutation step
// Leg numbering everywhere: 0 = A, 1 = B, 2 = C.
// ---------------------------------------------------------------------------
package bldc_pkg;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2
    } leg_req_t;

    typedef enum logic [1:0] {
        LEG_OFF  = 2'd0,
        LEG_HI   = 2'd1,
        LEG_LO   = 2'd2,
        LEG_DEAD = 2'd3
    } leg_state_t;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] sink;
    } comm_entry_t;

    localparam logic [2:0] STEP_INVALID = 3'd6;

    // Source leg is PWM-switched, sink leg holds its low side on.
    // Steps: A->B, A->C, B->C, B->A, C->A, C->B
    localparam comm_entry_t [0:5] COMM_TABLE = '{
        '{src: 2'd0, sink: 2'd1},
        '{src: 2'd0, sink: 2'd2},
        '{src: 2'd1, sink: 2'd2},
        '{src: 2'd1, sink: 2'd0},
        '{src: 2'd2, sink: 2'd0},
        '{src: 2'd2, sink: 2'd1}
    };

endpackage

// File: rtl/bldc_gate_driver_if.sv
// ---------------------------------------------------------------------------
// bldc_gate_driver_if
// Bundles the control inputs and gate outputs of the BLDC gate driver.
//   enable      : 1 = bridge may conduct; falling edge clears the fault latch
//   pwm_in      : registered PWM bit from the pwm stage
//   step        : commutation step 0..5 (6,7 invalid)
//   fault_n     : synchronous gate-driver fault, active low
//   gate_hi     : high-side enables [0]=A [1]=B [2]=C
//   gate_lo     : low-side enables, same ordering
//   fault_latch : sticky fault indicator
// master = the controller side driving the inputs, slave = the gate driver.
// ---------------------------------------------------------------------------
interface bldc_gate_driver_if;

    logic       enable;
    logic       pwm_in;
    logic [2:0] step;
    logic       fault_n;
    logic [2:0] gate_hi;
    logic [2:0] gate_lo;
    logic       fault_latch;

    modport master (
        output enable, pwm_in, step, fault_n,
        input  gate_hi, gate_lo, fault_latch
    );

    modport slave (
        input  enable, pwm_in, step, fault_n,
        output gate_hi, gate_lo, fault_latch
    );

endinterface

// File: rtl/bldc_phase_leg.sv
// ---------------------------------------------------------------------------
// bldc_phase_leg
// One inverter leg: FSM plus dead-time counter plus registered gate enables.
// Any hi<->lo swap passes through DEAD, where both switches stay off for
// DEAD_TIME cycles; a REQ_OFF aborts DEAD immediately.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : combinational request for this leg
//   o_gate_hi      : registered high-side enable
//   o_gate_lo      : registered low-side enable
// ---------------------------------------------------------------------------
module bldc_phase_leg
    import bldc_pkg::*;
#(
    parameter int DT_LEN    = 8,
    parameter int DEAD_TIME = 16
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  leg_req_t i_req,
    output logic     o_gate_hi,
    output logic     o_gate_lo
);

    localparam logic [DT_LEN-1:0] DEAD_LOAD = DT_LEN'(DEAD_TIME - 1);

    leg_state_t        r_state;
    leg_state_t        w_next_state;
    logic [DT_LEN-1:0] r_count;
    logic [DT_LEN-1:0] w_next_count;
    logic              r_gate_hi;
    logic              r_gate_lo;

    // Counter value loaded on entry to DEAD is DEAD_TIME-1 so that the
    // outputs are off for exactly DEAD_TIME cycles before the new side.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            LEG_OFF: begin
                if (i_req == REQ_HI) begin
                    w_next_state = LEG_HI;
                end else if (i_req == REQ_LO) begin
                    w_next_state = LEG_LO;
                end
            end
            LEG_HI: begin
                if (i_req == REQ_LO) begin
                    w_next_state = LEG_DEAD;
                    w_next_count = DEAD_LOAD;
                end else if (i_req == REQ_OFF) begin
                    w_next_state = LEG_OFF;
                end
            end
            LEG_LO: begin
                if (i_req == REQ_HI) begin
                    w_next_state = LEG_DEAD;
                    w_next_count = DEAD_LOAD;
                end else if (i_req == REQ_OFF) begin
                    w_next_state = LEG_OFF;
                end
            end
            LEG_DEAD: begin
                // Exit side follows the request present at expiry, so
                // returning to the original side still costs full dead time.
                if (i_req == REQ_OFF) begin
                    w_next_state = LEG_OFF;
                    w_next_count = '0;
                end else if (r_count == '0) begin
                    w_next_state = (i_req == REQ_HI) ? LEG_HI : LEG_LO;
                end else begin
                    w_next_count = r_count - 1'b1;
                end
            end
            default: begin
                w_next_state = LEG_OFF;
                w_next_count = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= LEG_OFF;
            r_count   <= '0;
            r_gate_hi <= 1'b0;
            r_gate_lo <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            r_gate_hi <= (w_next_state == LEG_HI);
            r_gate_lo <= (w_next_state == LEG_LO);
        end
    end

    assign o_gate_hi = r_gate_hi;
    assign o_gate_lo = r_gate_lo;

endmodule

// File: rtl/bldc_gate_driver.sv
// ---------------------------------------------------------------------------
// bldc_gate_driver
// Decodes the commutation step and PWM bit into per-leg requests, keeps the
// sticky gate-fault latch and drives three bldc_phase_leg instances.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : bldc_gate_driver_if.slave (enable, pwm_in, step,
//                    fault_n in; gate_hi, gate_lo, fault_latch out)
// Configuration macro SYNC_RECT_EN:
//   defined   : source leg pulls its low side on while pwm_in=0
//               (complementary PWM, every PWM edge goes through dead time)
//   undefined : source leg floats while pwm_in=0 (diode freewheel)
// ---------------------------------------------------------------------------
module bldc_gate_driver
    import bldc_pkg::*;
#(
    parameter int DT_LEN    = 8,
    parameter int DEAD_TIME = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    bldc_gate_driver_if.slave   bus
);

`ifdef SYNC_RECT_EN
    localparam leg_req_t SRC_IDLE_REQ = REQ_LO;
`else
    localparam leg_req_t SRC_IDLE_REQ = REQ_OFF;
`endif

    logic        r_enable_d;
    logic        r_fault_latch;
    logic        w_enable_fall;
    logic        w_blocked;
    comm_entry_t w_entry;
    leg_req_t    w_req [3];
    logic [2:0]  w_gate_hi;
    logic [2:0]  w_gate_lo;

    assign w_enable_fall = r_enable_d & ~bus.enable;

    // Clearing on the enable falling edge wins over a fault in the same
    // cycle; a fault still present re-latches on the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enable_d    <= 1'b0;
            r_fault_latch <= 1'b0;
        end else begin
            r_enable_d <= bus.enable;
            if (w_enable_fall) begin
                r_fault_latch <= 1'b0;
            end else if (!bus.fault_n) begin
                r_fault_latch <= 1'b1;
            end
        end
    end

    // A live fault_n low blocks requests directly, so the gates drop in the
    // same cycle the latch is being set.
    always_comb begin
        w_blocked = !bus.enable || r_fault_latch || !bus.fault_n ||
                    (bus.step >= STEP_INVALID);
        w_entry   = COMM_TABLE[0];
        if (bus.step < STEP_INVALID) begin
            w_entry = COMM_TABLE[bus.step];
        end
        for (int i = 0; i < 3; i++) begin
            w_req[i] = REQ_OFF;
            if (!w_blocked) begin
                if (2'(i) == w_entry.src) begin
                    w_req[i] = bus.pwm_in ? REQ_HI : SRC_IDLE_REQ;
                end else if (2'(i) == w_entry.sink) begin
                    w_req[i] = REQ_LO;
                end
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        bldc_phase_leg #(
            .DT_LEN    (DT_LEN),
            .DEAD_TIME (DEAD_TIME)
        ) u_leg (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_req     (w_req[g]),
            .o_gate_hi (w_gate_hi[g]),
            .o_gate_lo (w_gate_lo[g])
        );
    end

    assign bus.gate_hi     = w_gate_hi;
    assign bus.gate_lo     = w_gate_lo;
    assign bus.fault_latch = r_fault_latch;

endmodule
